// File: rtl/led_shift_scheduler.sv
// led_shift_scheduler: round-robin two-requester arbiter driving a serial LED shift-register chain.
module led_shift_scheduler #(
    parameter int WIDTH       = 8,
    parameter int clk_divider = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack1,
    output logic             busy,
    output logic             grant_id,
    output logic             leddata,
    output logic             ledclk,
    output logic             ledlatch
);
    localparam int CW = clk_divider > 0 ? $clog2(clk_divider + 1) : 1;
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH_HI, LATCH_LO} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [BW-1:0]    bits, bits_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic             ptr, ptr_nx, grant_nx, tick;
    logic             ack0_nx, ack1_nx, busy_nx, leddata_nx, ledclk_nx, ledlatch_nx;

    assign tick = cnt == CW'(clk_divider);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bits     <= '0;
            shreg    <= '0;
            ptr      <= 1'b0;
            grant_id <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
            leddata  <= 1'b0;
            ledclk   <= 1'b0;
            ledlatch <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            bits     <= bits_nx;
            shreg    <= shreg_nx;
            ptr      <= ptr_nx;
            grant_id <= grant_nx;
            ack0     <= ack0_nx;
            ack1     <= ack1_nx;
            busy     <= busy_nx;
            leddata  <= leddata_nx;
            ledclk   <= ledclk_nx;
            ledlatch <= ledlatch_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = (state == IDLE || state == LOAD || tick) ? '0 : cnt + 1'b1;
        bits_nx  = bits;
        shreg_nx = shreg;
        ptr_nx   = ptr;
        grant_nx = grant_id;
        case (state)
            IDLE: if (req0 || req1) begin
                grant_nx = (req0 && req1) ? ptr : req1;
                ptr_nx   = !grant_nx;
                state_nx = LOAD;
            end
            LOAD: begin
                shreg_nx = grant_id ? data1 : data0;
                bits_nx  = BW'(WIDTH - 1);
                state_nx = SHIFT_LO;
            end
            SHIFT_LO: if (tick) state_nx = SHIFT_HI;
            SHIFT_HI: if (tick) begin
                shreg_nx = {shreg[WIDTH-2:0], 1'b0};
                bits_nx  = (bits == '0) ? bits : bits - 1'b1;
                state_nx = (bits == '0) ? LATCH_HI : SHIFT_LO;
            end
            LATCH_HI: if (tick) state_nx = LATCH_LO;
            LATCH_LO: if (tick) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Pin values are decoded from the next state so every output leaves a flop.
    always_comb begin
        ack0_nx     = state_nx == LOAD && !grant_nx;
        ack1_nx     = state_nx == LOAD && grant_nx;
        busy_nx     = state_nx != IDLE;
        ledclk_nx   = state_nx == SHIFT_HI;
        ledlatch_nx = state_nx == LATCH_HI;
        leddata_nx  = (state_nx == SHIFT_LO || state_nx == SHIFT_HI) && shreg_nx[WIDTH-1];
    end
endmodule

// File: tb/tb_led_shift_scheduler.sv
// tb_led_shift_scheduler: transaction-level timeline model feeding a scoreboard, with one
// instance at divider 0 and one at divider 3.
module tb_led_shift_scheduler;
    localparam int D1 = 3;

    typedef struct {
        int         k;
        int         w;
        logic [7:0] d;
        int         e;
    } exp_t;

    logic       clk = 0;
    logic       rst;
    logic [1:0] rq [2];
    logic [7:0] dt [2][2];
    wire  [1:0] ak [2];
    wire  [1:0] bsy, gid, ld, lc, ll;

    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   free_e [2];
    bit   ptr_m [2];
    int   gnt [2][2];
    bit   act [2];
    exp_t expq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_shift_scheduler #(.WIDTH(8), .clk_divider(0)) u0 (
        .clk(clk), .rst(rst),
        .req0(rq[0][0]), .data0(dt[0][0]), .ack0(ak[0][0]),
        .req1(rq[0][1]), .data1(dt[0][1]), .ack1(ak[0][1]),
        .busy(bsy[0]), .grant_id(gid[0]),
        .leddata(ld[0]), .ledclk(lc[0]), .ledlatch(ll[0])
    );

    led_shift_scheduler #(.WIDTH(8), .clk_divider(D1)) u1 (
        .clk(clk), .rst(rst),
        .req0(rq[1][0]), .data0(dt[1][0]), .ack0(ak[1][0]),
        .req1(rq[1][1]), .data1(dt[1][1]), .ack1(ak[1][1]),
        .busy(bsy[1]), .grant_id(gid[1]),
        .leddata(ld[1]), .ledclk(lc[1]), .ledlatch(ll[1])
    );

    function automatic int dv(input int k);
        return k == 1 ? D1 : 0;
    endfunction

    task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s k=%0d: got %0h, expected %0h", nm, k, got, want);
    endtask

    task automatic model_reset();
        expq.delete();
        for (int k = 0; k < 2; k++) begin
            free_e[k] = 0;
            ptr_m[k]  = 0;
            gnt[k][0] = -1;
            gnt[k][1] = -1;
        end
    endtask

    // Called at a negedge: drives inputs for the coming edge, predicts any grant, then waits.
    task automatic step(input int k, input int p_req, input int p_wd);
        int n, w;
        n = cyc;
        for (int r = 0; r < 2; r++) begin
            if (gnt[k][r] >= 0) begin
                if (n >= gnt[k][r] + 2) begin
                    rq[k][r]  = 1'b0;
                    gnt[k][r] = -1;
                end
            end else if (!rq[k][r] && int'($urandom_range(99)) < p_req) begin
                rq[k][r] = 1'b1;
                dt[k][r] = 8'($urandom);
            end else if (rq[k][r] && int'($urandom_range(99)) < p_wd) begin
                rq[k][r] = 1'b0;
            end
        end
        if (n >= free_e[k] && rq[k] != 2'b00) begin
            w = (rq[k] == 2'b11) ? int'(ptr_m[k]) : int'(rq[k][1]);
            ptr_m[k]  = (w == 0);
            gnt[k][w] = n;
            expq.push_back('{k: k, w: w, d: dt[k][w], e: n});
            free_e[k] = n + 2 + 18 * (dv(k) + 1);
        end
        @(negedge clk);
    endtask

    task automatic drain(input int k);
        int b = 0;
        while ((rq[k] != 2'b00 || cyc <= free_e[k]) && b < 4000) begin
            step(k, 0, 0);
            b++;
        end
        chk("drain_bound", k, 64'(b < 4000), 64'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rq[0] = 2'b00;
        rq[1] = 2'b00;
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk("reset_outputs", k, 64'({ak[k], bsy[k], gid[k], ld[k], lc[k], ll[k]}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic mon(input int k);
        exp_t       cur = '{k: 0, w: 0, d: 8'h00, e: 0};
        logic [7:0] sh = 8'h00;
        int         nb = 0, hl = 0, lo = 0, lh = 0, nl = 0;
        bit         plc = 0, pll = 0, pb = 0, bad = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act[k] = 0;
                plc = 0;
                pll = 0;
                pb  = 0;
            end else begin
                if (lc[k] && !plc) begin
                    sh = {sh[6:0], ld[k]};
                    nb++;
                    if (lo != dv(k) + 1) bad = 1;
                    lo = 0;
                end else if (!lc[k]) lo++;
                if (lc[k]) hl++;
                else begin
                    if (plc && hl != dv(k) + 1) bad = 1;
                    hl = 0;
                end
                if (ll[k]) lh++;
                else begin
                    if (pll && lh != dv(k) + 1) bad = 1;
                    lh = 0;
                end
                if (ll[k] && !pll) begin
                    nl++;
                    chk("frame_data", k, 64'(sh), 64'(cur.d));
                    chk("frame_bits", k, 64'(nb), 64'(8));
                end
                if (|ak[k]) begin
                    if (expq.size() == 0 || expq[0].k != k)
                        chk("spurious_ack", k, 64'(ak[k]), 64'(0));
                    else begin
                        cur = expq.pop_front();
                        chk("ack_sel", k, 64'(ak[k]), 64'(cur.w != 0 ? 2 : 1));
                        chk("ack_edge", k, 64'(cyc - 1), 64'(cur.e));
                        chk("grant_id", k, 64'(gid[k]), 64'(cur.w));
                        chk("busy_rise", k, 64'(bsy[k]), 64'(1));
                        act[k] = 1;
                        sh = 8'h00;
                        nb = 0; nl = 0; lo = 0; hl = 0; lh = 0; bad = 0;
                    end
                end
                if (pb && !bsy[k]) begin
                    chk("busy_fall_edge", k, 64'(cyc - 1), 64'(cur.e + 1 + 18 * (dv(k) + 1)));
                    chk("phase_lengths", k, 64'(bad), 64'(0));
                    chk("latch_pulses", k, 64'(nl), 64'(1));
                    chk("idle_pins", k, 64'({ld[k], lc[k], ll[k]}), 64'(0));
                    act[k] = 0;
                end
                plc = lc[k];
                pll = ll[k];
                pb  = bsy[k];
            end
        end
    endtask

    initial mon(0);
    initial mon(1);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        rst = 1'b1;
        rq[0] = 2'b00;
        rq[1] = 2'b00;
        for (int k = 0; k < 2; k++) begin
            dt[k][0] = 8'h00;
            dt[k][1] = 8'h00;
        end
        do_reset();

        // simultaneous requests straight out of reset, then a re-raised req0
        rq[0] = 2'b11;
        dt[0][0] = 8'h0F;
        dt[0][1] = 8'hF0;
        step(0, 0, 0);
        while (rq[0][0]) step(0, 0, 0);
        rq[0][0] = 1'b1;
        dt[0][0] = 8'h3C;
        drain(0);

        // single frame, divider 0
        rq[0][0] = 1'b1;
        dt[0][0] = 8'hA5;
        drain(0);

        // single frame, divider 3
        rq[1][0] = 1'b1;
        dt[1][0] = 8'h81;
        drain(1);

        // request arriving mid-transfer
        rq[0][0] = 1'b1;
        dt[0][0] = 8'h5A;
        repeat (6) step(0, 0, 0);
        rq[0][1] = 1'b1;
        dt[0][1] = 8'h96;
        drain(0);

        // one-cycle request while busy, withdrawn
        rq[0][1] = 1'b1;
        dt[0][1] = 8'h33;
        repeat (5) step(0, 0, 0);
        rq[0][0] = 1'b1;
        dt[0][0] = 8'hEE;
        step(0, 0, 0);
        rq[0][0] = 1'b0;
        drain(0);
        repeat (5) step(0, 0, 0);
        chk("idle_after_withdraw", 0, 64'(bsy[0]), 64'(0));

        // reset during the third ledclk high phase
        rq[0][0] = 1'b1;
        dt[0][0] = 8'hC3;
        step(0, 0, 0);
        e = gnt[0][0];
        while (cyc < e + 7) step(0, 0, 0);
        chk("third_clk_high", 0, 64'(lc[0]), 64'(1));
        do_reset();
        repeat (4) step(0, 0, 0);
        rq[0] = 2'b11;
        dt[0][0] = 8'($urandom);
        dt[0][1] = 8'($urandom);
        drain(0);

        // randomized traffic with withdrawals
        repeat (3000) step(0, 8, 3);
        drain(0);
        repeat (1500) step(1, 8, 3);
        drain(1);

        chk("queue_empty", 0, 64'(expq.size()), 64'(0));
        for (int k = 0; k < 2; k++) chk("frame_closed", k, 64'(act[k]), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/led_shift_scheduler.md
Name: led_shift_scheduler

Overview:
- Arbitrated controller for the board's serial LED shift-register chain (leddata / ledclk / ledlatch).
- Two requesters submit WIDTH-bit frames over a req/ack handshake; the block grants one round-robin, captures its frame, and sequences the serial transfer MSB-first.
- The transfer is paced by a clock-divider tick and ends with a latch pulse.
- Sits between the LED pattern logic and the top-level LED pins.

Parameters:
WIDTH, 8, bits per frame (shift-register chain length), must be >= 2
clk_divider, 0, phase tick every clk_divider+1 clk cycles (0 = every cycle)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req0  in  1  requester 0 frame request, held until ack0
data0  in  WIDTH  requester 0 frame, stable while req0 high
ack0  out  1  one-cycle pulse: data0 captured
req1  in  1  requester 1 frame request, held until ack1
data1  in  WIDTH  requester 1 frame, stable while req1 high
ack1  out  1  one-cycle pulse: data1 captured
busy  out  1  high whenever state != IDLE
grant_id  out  1  requester served by current/last transfer
leddata  out  1  serial data to chain
ledclk  out  1  chain shift clock
ledlatch  out  1  chain storage latch

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; divider count 0; bit counter 0; round-robin pointer prefers requester 0.
- Reset mid-transfer aborts the transfer:
  - no ack is issued;
  - the captured frame is discarded;
  - ledclk and ledlatch drop to 0 on the next edge.
- Divider:
  - count increments each cycle outside IDLE/LOAD.
  - tick = (count == clk_divider); on a tick, count returns to 0.
  - count is forced to 0 in IDLE and LOAD.
- States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH_HI, LATCH_LO.
- IDLE:
  - Outputs ledclk = 0, ledlatch = 0.
  - If any req is high, go to LOAD and record the winner in grant_id.
  - If only one req is high, it wins.
  - If both are high, the winner is the requester not served last (pointer). After a grant, the pointer toggles to the loser.
- LOAD (exactly 1 cycle, ignores tick):
  - Pulse ack[grant_id] = 1 and capture data[grant_id] into the shift register.
  - Bit counter = WIDTH-1.
  - Next state SHIFT_LO.
- SHIFT_LO: ledclk = 0; leddata = shreg[WIDTH-1]. On tick, go to SHIFT_HI.
- SHIFT_HI:
  - ledclk = 1; leddata unchanged.
  - On tick: shreg shifts left by 1, ledclk falls.
    - If bit counter == 0, go to LATCH_HI.
    - Otherwise decrement the counter and go to SHIFT_LO.
- LATCH_HI: ledlatch = 1, ledclk = 0. On tick, go to LATCH_LO.
- LATCH_LO: ledlatch = 0. On tick, go to IDLE. leddata returns to 0 in IDLE.
- Outputs are registered; leddata is stable for a full phase on each side of the ledclk rising edge.
- Latency with clk_divider = D:
  - 1 IDLE decision cycle;
  - 1 LOAD cycle;
  - (2·WIDTH + 2)·(D+1) cycles of transfer.
- Example: WIDTH = 8, D = 0 gives 20 cycles from the first req-high edge to busy low.
- A req arriving while busy is held off; it is serviced in the next IDLE.
- IDLE lasts at least 1 cycle between transfers, so back-to-back frames have a 1-cycle gap.
- req dropped before ack: the request is withdrawn, with no effect unless LOAD was already entered. If LOAD was entered, the capture still occurs.
- ack is never asserted for a requester whose req was low in the granting IDLE cycle.

Test Plan:
1. Single frame, D=0, WIDTH=8:
   - Stimulus: req0 = 1, data0 = 8'hA5.
   - Required: ack0 pulses exactly 1 cycle; 8 ledclk rising edges sample leddata 1,0,1,0,0,1,0,1; then one 1-cycle ledlatch pulse; busy low after 20 cycles total.
2. Simultaneous requests after reset:
   - Stimulus: req0 = req1 = 1, data0 = 8'h0F, data1 = 8'hF0, both held.
   - Required: first transfer is 8'h0F with grant_id = 0; second is 8'hF0 with grant_id = 1; a third still-pending req0 is served next.
3. Divider, D=3:
   - Stimulus: single frame 8'h81.
   - Required: each ledclk high/low phase is 4 cycles; ledlatch high for 4 cycles; total 2 + 18·4 = 74 cycles.
4. Reset mid-transfer:
   - Stimulus: assert rst during the 3rd SHIFT_HI.
   - Required: next edge gives ledclk = 0, ledlatch = 0, leddata = 0, busy = 0, and no further ack.
   - After release, with req1 and req0 both high, requester 0 wins (pointer reset).
5. Request during busy:
   - Stimulus: req1 rises in the middle of a req0 transfer.
   - Required: ack1 does not pulse until the cycle after busy falls (IDLE + 1); no ledlatch pulse is missed or duplicated.
6. Withdrawn request:
   - Stimulus: req0 pulses high for 1 cycle while busy, then drops.
   - Required: no ack0 and no extra transfer; busy stays low after the current frame.
